// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - two-requester controller sharing one external ALU; optional ALU_SHARE_RR_EN selects round-robin tie breaking
module alu_share_ctrl #(
  parameter int N       = 64,
  parameter int NUM_OPS = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [5:0]   req0_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [5:0]   req1_sel,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic [N-1:0] rsp_upper,
  output logic [6:0]   rsp_flags,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [5:0]   alu_sel,
  input  logic [N-1:0] alu_result,
  input  logic [N-1:0] alu_upper,
  input  logic [6:0]   alu_flags,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [6:0] NUM_OPS_W = 7'(NUM_OPS);

  state_t       state;
  state_t       state_nxt;
  logic         grant0;
  logic         grant1;
  logic         id_q;
  logic         err_q;
  logic [N-1:0] g_a;
  logic [N-1:0] g_b;
  logic [5:0]   g_sel;
  logic         g_err;

`ifdef ALU_SHARE_RR_EN
  logic last_grant;

  // round-robin: on a tie the requester that did not win last time is granted
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // remember the most recent winner; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      last_grant <= grant1;
    end
  end
`else
  // fixed priority: requester 0 always wins a tie
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
    end
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  // operand mux for whichever requester is granted this cycle
  always_comb begin
    g_a   = req0_a;
    g_b   = req0_b;
    g_sel = req0_sel;
    if (grant1) begin
      g_a   = req1_a;
      g_b   = req1_b;
      g_sel = req1_sel;
    end
    g_err = ({1'b0, g_sel} >= NUM_OPS_W);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: one accept per IDLE, one settle cycle, then hold response until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant0 || grant1) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: launch operands on grant, capture ALU outputs at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_upper  <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        alu_a   <= g_a;
        alu_b   <= g_b;
        alu_sel <= g_sel;
        id_q    <= grant1;
        err_q   <= g_err;
      end
      if (state == EXEC) begin
        rsp_id  <= id_q;
        rsp_err <= err_q;
        if (err_q) begin
          rsp_result <= '0;
          rsp_upper  <= '0;
          rsp_flags  <= '0;
        end else begin
          rsp_result <= alu_result;
          rsp_upper  <= alu_upper;
          rsp_flags  <= alu_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl with an adder ALU stub
module tb_alu_share_ctrl;

  localparam int N = 64;
`ifdef ALU_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]   req0_sel, req1_sel;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [N-1:0] rsp_result, rsp_upper, alu_a, alu_b, alu_result, alu_upper;
  logic [6:0]   rsp_flags, alu_flags;
  logic [5:0]   alu_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  sel;
    logic [63:0] e_res;
    logic [63:0] e_up;
    logic [6:0]  e_flags;
    bit          e_err;
  } vec_t;

  typedef struct {
    bit          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  sel;
  } op_t;

  vec_t vecs[6];
  op_t  expq[$];

  always #5 clk = ~clk;

  assign alu_result = alu_a + alu_b;
  assign alu_upper  = {58'b0, alu_sel};
  assign alu_flags  = 7'h55;

  alu_share_ctrl #(.N(N), .NUM_OPS(35)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_upper(rsp_upper), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_upper(alu_upper), .alu_flags(alu_flags),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input bit id, input logic [63:0] a, input logic [63:0] b, input logic [5:0] sel);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end
  endtask

  // one full transaction from IDLE with rsp_ready held high; ends one cycle after the handshake
  task automatic run_vec(input vec_t v);
    rsp_ready = 1'b1;
    drive(v.id, v.a, v.b, v.sel);
    #1;
    chk("vec_ready", v.id ? req1_ready : req0_ready, 1);
    chk("vec_other_ready", v.id ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("vec_busy_exec", busy, 1);
    chk("vec_alu_a", alu_a, v.a);
    chk("vec_alu_sel", alu_sel, v.sel);
    chk("vec_rsp_valid_exec", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_id", rsp_id, v.id);
    chk("vec_rsp_result", rsp_result, v.e_res);
    chk("vec_rsp_upper", rsp_upper, v.e_up);
    chk("vec_rsp_flags", rsp_flags, v.e_flags);
    chk("vec_rsp_err", rsp_err, v.e_err);
    @(negedge clk);
    #1;
    chk("vec_rsp_valid_after", rsp_valid, 0);
    chk("vec_busy_after", busy, 0);
  endtask

  initial begin
    int wins[$];
    int wcyc[$];
    int resp_count;
    int model_last;
    bit pv[2];
    bit acc[2];
    logic [63:0] pa[2];
    logic [63:0] pb[2];
    logic [5:0]  ps[2];

    req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_a = '0; req1_b = '0; req1_sel = '0;

    // reset state, with valids high to show ready is held low during reset
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_upper", rsp_upper, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    reset_dut();

    // directed vectors
    vecs[0] = '{0, 64'd5, 64'd7, 6'd3, 64'd12, 64'd3, 7'h55, 0};
    vecs[1] = '{1, 64'd1, 64'd1, 6'd40, 64'd0, 64'd0, 7'h00, 1};
    vecs[2] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 64'd0, 64'd0, 7'h55, 0};
    vecs[3] = '{1, 64'd10, 64'd20, 6'd34, 64'd30, 64'd34, 7'h55, 0};
    vecs[4] = '{0, 64'd3, 64'd4, 6'd35, 64'd0, 64'd0, 7'h00, 1};
    vecs[5] = '{1, 64'd100, 64'd200, 6'd63, 64'd0, 64'd0, 7'h00, 1};
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // tie: both requesters valid continuously
    reset_dut();
    rsp_ready = 1'b1;
    drive(0, 64'd1, 64'd2, 6'd3);
    drive(1, 64'd4, 64'd5, 6'd6);
    for (int cyc = 0; cyc < 40 && wins.size() < 4; cyc++) begin
      #1;
      if (req0_ready && req1_ready) chk("tie_one_ready", 2, 1);
      if (req0_ready) begin wins.push_back(0); wcyc.push_back(cyc); end
      else if (req1_ready) begin wins.push_back(1); wcyc.push_back(cyc); end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_grant_count", wins.size(), 4);
    for (int i = 0; i < wins.size(); i++) begin
      chk("tie_winner", wins[i], RR ? (i % 2) : 0);
      if (i > 0) chk("tie_spacing", wcyc[i] - wcyc[i-1], 3);
    end
    repeat (3) @(negedge clk);

    // backpressure: five cycles of rsp_ready=0 after rsp_valid rises
    rsp_ready = 1'b0;
    drive(0, 64'd11, 64'd22, 6'd5);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    drive(0, 64'd7, 64'd7, 6'd1);
    drive(1, 64'd8, 64'd8, 6'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 33);
      chk("bp_rsp_upper", rsp_upper, 5);
      chk("bp_rsp_id", rsp_id, 0);
      chk("bp_req_ready", {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_valid", rsp_valid, 1);
    chk("bp_hs_req_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    #1;
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_next_grant", req0_ready | req1_ready, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // reset in the EXEC cycle drops the operation
    rsp_ready = 1'b1;
    drive(0, 64'd9, 64'd9, 6'd2);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("mid_busy_exec", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_alu_a", alu_a, 0);
    rst = 1'b0;
    drive(0, 64'd40, 64'd2, 6'd7);
    #1;
    chk("mid_new_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("mid_no_rsp", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("mid_new_valid", rsp_valid, 1);
    chk("mid_new_result", rsp_result, 42);
    chk("mid_new_upper", rsp_upper, 7);
    @(negedge clk);

    // randomized traffic against a transaction-level model
    reset_dut();
    model_last = 1;
    resp_count = 0;
    pv[0] = 0; pv[1] = 0; acc[0] = 0; acc[1] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) begin pv[r] = 0; acc[r] = 0; end
        if (!pv[r] && cyc < 1400 && $urandom_range(0, 2) == 0) begin
          pv[r] = 1;
          pa[r] = {$urandom, $urandom};
          pb[r] = {$urandom, $urandom};
          ps[r] = 6'($urandom_range(0, 63));
        end
      end
      req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_sel = ps[0];
      req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_sel = ps[1];
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (req0_ready && req1_ready) chk("rnd_one_ready", 2, 1);
      if (req0_ready || req1_ready) begin
        int w;
        op_t o;
        if (pv[0] && pv[1]) w = RR ? ((model_last == 1) ? 0 : 1) : 0;
        else w = pv[1] ? 1 : 0;
        chk("rnd_grant", req1_ready, w);
        chk("rnd_grant_when_idle", expq.size(), 0);
        o.id = w[0]; o.a = pa[w]; o.b = pb[w]; o.sel = ps[w];
        expq.push_back(o);
        acc[w] = 1;
        model_last = w;
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          chk("rnd_spurious_rsp", 1, 0);
        end else begin
          op_t o;
          bit bad;
          o = expq.pop_front();
          bad = (o.sel >= 35);
          resp_count++;
          chk("rnd_id", rsp_id, o.id);
          chk("rnd_err", rsp_err, bad);
          chk("rnd_result", rsp_result, bad ? 64'd0 : o.a + o.b);
          chk("rnd_upper", rsp_upper, bad ? 64'd0 : 64'(o.sel));
          chk("rnd_flags", rsp_flags, bad ? 7'h00 : 7'h55);
        end
      end
      @(negedge clk);
    end
    chk("rnd_drained", expq.size(), 0);
    chk("rnd_progress", resp_count > 50, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
